// File: rtl/store_buffer.sv
// Write-side store buffer: queues core stores and drains them in order to the memory
// controller, holding each head entry steady for the controller's two-cycle write.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [1:0]                 st_acc_i,
  input  logic [31:0]                st_addr_i,
  input  logic [31:0]                st_data_i,
  output logic                       st_misalign_o,
  input  logic                       ld_valid_i,
  input  logic [31:0]                ld_addr_i,
  output logic                       ld_block_o,
  output logic                       wr_en_o,
  output logic [1:0]                 acc_w_o,
  output logic [31:0]                addr_w_o,
  output logic [31:0]                data_w_o,
  input  logic                       wr_ready_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] MEM_ACCESS_BYTE     = 2'b00;
  localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'b01;
  localparam logic [1:0] MEM_ACCESS_WORD     = 2'b10;

  typedef enum logic {ISSUE, COMMIT} state_t;

  state_t        state_reg;
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          misalign_reg;

  logic [1:0]    acc_mem  [DEPTH];
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic             empty;
  logic             misaligned;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit;
  logic             ld_addr_unused;

  assign empty      = (count_reg == '0);
  assign st_ready_o = (count_reg != CW'(DEPTH));
  assign misaligned = ((st_acc_i == MEM_ACCESS_HALFWORD) && st_addr_i[0]) ||
                      ((st_acc_i == MEM_ACCESS_WORD) && (st_addr_i[1:0] != 2'b00));
  assign push       = st_valid_i && st_ready_o && !misaligned;
  assign pop        = (state_reg == COMMIT);
  assign count_next = count_reg + CW'(push) - CW'(pop);

  assign wr_en_o  = (state_reg == ISSUE) && !empty;
  assign acc_w_o  = empty ? 2'b00 : acc_mem[head_reg];
  assign addr_w_o = empty ? 32'h0 : addr_mem[head_reg];
  assign data_w_o = empty ? 32'h0 : data_mem[head_reg];

  assign empty_o       = empty;
  assign count_o       = count_reg;
  assign st_misalign_o = misalign_reg;

  // An entry is live when its distance from head is below count; this covers the head in COMMIT.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] offset;
      assign offset  = PW'(gi) - head_reg;
      assign hit[gi] = ({1'b0, offset} < count_reg) &&
                       (addr_mem[gi][31:2] == ld_addr_i[31:2]);
    end
  endgenerate

  // Loads compare at word granularity only.
  assign ld_addr_unused = ^ld_addr_i[1:0];
  assign ld_block_o     = ld_valid_i && (wr_en_o || pop || (|hit));

  always_ff @(posedge clk_i) begin
    if (push) begin
      acc_mem[tail_reg]  <= st_acc_i;
      addr_mem[tail_reg] <= st_addr_i;
      data_mem[tail_reg] <= st_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ISSUE;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= st_valid_i && st_ready_o && misaligned;
      count_reg    <= count_next;
      if (push) tail_reg <= tail_reg + 1'b1;
      case (state_reg)
        ISSUE: begin
          if (wr_en_o && wr_ready_i) state_reg <= COMMIT;
        end
        COMMIT: begin
          head_reg  <= head_reg + 1'b1;
          state_reg <= ISSUE;
        end
        default: state_reg <= ISSUE;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side buffer between the core's store path and the memory controller's write port. Queues up to DEPTH stores so the core never waits on the controller's two-cycle read-modify-write. Drains them in order under the controller's `wr_ready` handshake. Provides a load-blocking signal so loads never read stale data and never collide with an in-flight write.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `st_valid_i` in 1: core presents a store.
- `st_ready_o` out 1: buffer accepts the store this cycle.
- `st_acc_i` in 2: access size, `MEM_ACCESS_BYTE`, `MEM_ACCESS_HALFWORD` or `MEM_ACCESS_WORD`.
- `st_addr_i` in 32: byte address.
- `st_data_i` in 32: store data, right-aligned.
- `st_misalign_o` out 1: one-cycle pulse; the previous cycle's accepted store was misaligned and dropped.
- `ld_valid_i` in 1: core wants to issue a load this cycle.
- `ld_addr_i` in 32: load byte address.
- `ld_block_o` out 1: load must not be issued this cycle.
- `wr_en_o` out 1: write request to the memory controller.
- `acc_w_o` out 2: head entry size.
- `addr_w_o` out 32: head entry address.
- `data_w_o` out 32: head entry data.
- `wr_ready_i` in 1: controller is ready and will take a request this cycle.
- `empty_o` out 1: no entries held.
- `count_o` out $clog2(DEPTH)+1: entries held.

## Operation
- Storage: circular FIFO of {acc, addr, data} with head/tail pointers of $clog2(DEPTH) bits, wrapping at DEPTH, plus a count register.
- Push:
  - Occurs when `st_valid_i && st_ready_o`.
  - `st_ready_o = (count != DEPTH)`. A push into a full buffer is refused, even in a cycle where a pop occurs.
- Misalignment:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is misaligned.
  - It completes the handshake, is not enqueued, and `st_misalign_o` is 1 in the following cycle.
- Drain FSM, two states:
  - ISSUE: `wr_en_o = !empty`. If `wr_en_o && wr_ready_i`, go to COMMIT.
  - COMMIT: `wr_en_o = 0`. `acc_w_o`, `addr_w_o` and `data_w_o` stay equal to the head entry, because the controller reuses them in its second cycle. At the end of the cycle, pop the head and go to ISSUE.
- Memory outputs always show the head entry while non-empty, and are 0 when empty.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Load blocking: `ld_block_o = ld_valid_i && (wr_en_o || state==COMMIT || match)`.
  - `match` is any held entry, including the head during COMMIT, with addr[31:2] == ld_addr_i[31:2].
  - The store being pushed in the same cycle is not included.
- Ordering: stores drain strictly in acceptance order. No merging or coalescing.

## Timing
- Reset values:
  - count=0, pointers=0, state=ISSUE.
  - `wr_en_o`=0, `acc_w_o`/`addr_w_o`/`data_w_o`=0.
  - `st_misalign_o`=0, `empty_o`=1, `st_ready_o`=1, `ld_block_o`=0.
- Reset mid-operation: all entries are discarded, including a store in COMMIT. No write is issued after reset release.
- Latency into an empty buffer:
  - Store accepted in cycle N.
  - `wr_en_o`=1 in N+1.
  - If `wr_ready_i`, COMMIT in N+2.
  - Entry popped at the end of N+2.
- Sustained throughput: one store per 2 cycles.
- Combinational outputs: `st_ready_o`, `ld_block_o` and `wr_en_o` are combinational from registers and `ld_*` inputs only. There is no path from `wr_ready_i` to `st_ready_o`.
- `count_o` and `empty_o` are registered-state derived and update the cycle after a push or pop.

## Test plan
- Empty buffer; word store at 0x100, data 0xDEADBEEF, cycle 0 -> `wr_en_o`=1, `addr_w_o`=0x100, `data_w_o`=0xDEADBEEF in cycle 1. With `wr_ready_i`=1: `wr_en_o`=0 and outputs held in cycle 2; `empty_o`=1 in cycle 3.
- `wr_ready_i`=0 and DEPTH=4: push 5 back-to-back stores -> 4 accepted, `st_ready_o`=0 on the 5th with count=4. Release `wr_ready_i` -> drain in order at 1 write per 2 cycles; the 5th is accepted the cycle after the first pop.
- Buffered byte store at 0x203; load at 0x200 -> `ld_block_o`=1. Load at 0x204 while idle (not ISSUE with `wr_en_o`, not COMMIT) -> `ld_block_o`=0 once the entry drains.
- Halfword store at 0x101 -> handshake completes, `st_misalign_o`=1 the next cycle, count stays 0, no `wr_en_o`.
- Push and pop in the same cycle at count=2 -> count stays 2; tail and head pointers wrap correctly across DEPTH.
- Assert `rst_i` during COMMIT with 3 entries held -> next cycle count=0 and `wr_en_o`=0. After release, no write is issued.
